// File: rtl/bsr_piso_pkg.sv
// bsr_piso_pkg: shared direction constants and state encoding for the PISO stream family
package bsr_piso_pkg;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: loadable down-counter with zero flag
module piso_bit_cnt
  import bsr_piso_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] init,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  // load wins over decrement; counter holds otherwise
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= init;
    else if (dec) cnt <= cnt - CNT_W'(1);
  assign zero = (cnt == '0);
endmodule

// File: rtl/bsr_piso_stream.sv
// bsr_piso_stream: WIDTH-bit bidirectional PISO with load handshake and stall; optional BSR_PISO_PARITY_EN parity bit
module bsr_piso_stream
  import bsr_piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             mode,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             frame_done
);
`ifdef BSR_PISO_PARITY_EN
  localparam state_t LAST_NX = PAR;
  logic par;
`else
  localparam state_t LAST_NX = IDLE;
`endif
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic dir, zero, step, accept, done_ev, data_bit;
  assign step = (state == SHIFT) && shift_en;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // handshake, frame completion and next state
  always_comb begin
    load_ready = 1'b0;
    done_ev = 1'b0;
`ifdef BSR_PISO_PARITY_EN
    load_ready = (state == IDLE) || ((state == PAR) && shift_en);
    done_ev = (state == PAR) && shift_en;
`else
    load_ready = (state == IDLE) || (step && zero);
    done_ev = step && zero;
`endif
    accept = load_valid && load_ready;
    state_nx = accept ? SHIFT : (step && zero) ? LAST_NX : ((state == PAR) && shift_en) ? IDLE : state;
  end
  // shift register, latched direction/parity and registered done pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shreg <= '0;
      dir <= DIR_RIGHT;
      frame_done <= 1'b0;
`ifdef BSR_PISO_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      frame_done <= done_ev;
      if (accept) begin
        shreg <= pin;
        dir <= mode;
`ifdef BSR_PISO_PARITY_EN
        par <= ^pin;
`endif
      end else if (step)
        shreg <= zero ? '0 : (dir == DIR_LEFT) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    end
  piso_bit_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .dec (step && !zero),
    .init(CNT_W'(WIDTH - 1)),
    .cnt (cnt),
    .zero(zero)
  );
  assign data_bit = (dir == DIR_LEFT) ? shreg[WIDTH-1] : shreg[0];
`ifdef BSR_PISO_PARITY_EN
  assign sout = (state == PAR) ? par : data_bit;
`else
  assign sout = data_bit;
`endif
  assign sout_valid = (state != IDLE);
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_bsr_piso_stream.sv
// tb_bsr_piso_stream: scoreboard bench for bsr_piso_stream at WIDTH=4 and WIDTH=8
module tb_bsr_piso_stream;
  typedef struct packed {logic b; logic last;} exp_t;
  logic clk = 0, rst = 0;
  logic [7:0] pin = '0;
  logic mode = 0, lv = 0, shift_en = 1, sel = 0;
  logic lr4, so4, sv4, b4, fd4, lr8, so8, sv8, b8, fd8;
  logic lr, so, sv, bsy, fd;
  exp_t q[$];
  int errors = 0, checks = 0, consumed = 0, done_cnt = 0, busy_cyc = 0, first_c = 0, last_c = 0, cyc = 0;
  bit pend_done = 0;
`ifdef BSR_PISO_PARITY_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif

  always #5 clk = ~clk;

  bsr_piso_stream #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .pin(pin[3:0]), .mode(mode), .load_valid(lv && !sel), .load_ready(lr4),
    .shift_en(shift_en), .sout(so4), .sout_valid(sv4), .busy(b4), .frame_done(fd4)
  );
  bsr_piso_stream #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .pin(pin), .mode(mode), .load_valid(lv && sel), .load_ready(lr8),
    .shift_en(shift_en), .sout(so8), .sout_valid(sv8), .busy(b8), .frame_done(fd8)
  );
  assign lr = sel ? lr8 : lr4;
  assign so = sel ? so8 : so4;
  assign sv = sel ? sv8 : sv4;
  assign bsy = sel ? b8 : b4;
  assign fd = sel ? fd8 : fd4;

  // scoreboard monitor: consume one expected bit per valid+shift_en cycle, check done pulse timing
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) pend_done = 0;
    else begin
      checks++;
      if (fd !== pend_done) begin
        errors++;
        $display("FAIL frame_done t=%0t: got %b want %b", $time, fd, pend_done);
      end
      if (fd === 1'b1) done_cnt++;
      pend_done = 0;
      if (bsy) busy_cyc++;
      if (sv && shift_en) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit t=%0t: got valid bit %b want none", $time, so);
        end else begin
          e = q.pop_front();
          if (so !== e.b) begin
            errors++;
            $display("FAIL sout t=%0t: got %b want %b", $time, so, e.b);
          end
          pend_done = e.last;
          consumed++;
          if (consumed == 1) first_c = cyc;
          last_c = cyc;
        end
      end
    end
  end

  task automatic offer(input logic [7:0] d, input logic m, input int w);
    exp_t e;
    logic p;
    int n;
    p = 0;
    for (int i = 0; i < w; i++) begin
      e.b = m ? d[w-1-i] : d[i];
      e.last = (i == w - 1) && (XB == 0);
      p = p ^ d[i];
      q.push_back(e);
    end
    if (XB == 1) begin
      e.b = p;
      e.last = 1;
      q.push_back(e);
    end
    pin = d;
    mode = m;
    lv = 1;
    n = 0;
    @(negedge clk);
    while (!lr && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!lr) begin
      errors++;
      $display("FAIL accept_timeout: got load_ready=%b want 1", lr);
    end
    @(posedge clk);
    #1 lv = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bits pending want 0", q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if ({so, sv, bsy, fd, lr} !== 5'b00001) begin
      errors++;
      $display("FAIL %s: got sout/valid/busy/done/ready=%b want 00001", nm, {so, sv, bsy, fd, lr});
    end
  endtask

  task automatic test_reset();
    #20;
    checks++;
    if ({so4, sv4, b4, fd4, lr4, so8, sv8, b8, fd8, lr8} !== 10'b00001_00001) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000100001", {so4, sv4, b4, fd4, lr4, so8, sv8, b8, fd8, lr8});
    end
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_left4();
    int d0;
    sel = 0;
    d0 = done_cnt;
    offer(8'h0B, 1, 4);
    drain();
    check_idle("left4_idle");
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL left4_done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_right4_mode_toggle();
    int d0;
    sel = 0;
    d0 = done_cnt;
    offer(8'h07, 0, 4);
    mode = 1;
    @(posedge clk);
    #1 mode = 0;
    @(posedge clk);
    #1 mode = 1;
    drain();
    check_idle("right4_idle");
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL right4_done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    sel = 1;
    d0 = done_cnt;
    consumed = 0;
    offer(8'hA5, 1, 8);
    offer(8'h3C, 0, 8);
    drain();
    checks++;
    if (last_c - first_c + 1 != 16 + 2 * XB) begin
      errors++;
      $display("FAIL b2b_span: got %0d cycles want %0d", last_c - first_c + 1, 16 + 2 * XB);
    end
    checks++;
    if (done_cnt - d0 != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0);
    end
  endtask

  task automatic test_stall();
    sel = 1;
    busy_cyc = 0;
    offer(8'hF0, 1, 8);
    @(posedge clk);
    @(posedge clk);
    #1 shift_en = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (so !== q[0].b || lr !== 1'b0 || sv !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: got sout=%b ready=%b valid=%b want %b 0 1", so, lr, sv, q[0].b);
      end
    end
    @(posedge clk);
    #1 shift_en = 1;
    drain();
    checks++;
    if (busy_cyc != 11 + XB) begin
      errors++;
      $display("FAIL stall_frame_len: got %0d want %0d", busy_cyc, 11 + XB);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    sel = 1;
    offer(8'h81, 1, 8);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1 check_idle("midreset_outputs");
    q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d pulses want 0", done_cnt - d0);
    end
    @(posedge clk);
    #1 offer(8'h01, 0, 8);
    drain();
    check_idle("after_reset_idle");
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL after_reset_done: got %0d want 1", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_left4();
    test_right4_mode_toggle();
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
